// File: rtl/forward_hazard_ctrl.sv
// Operand forwarding select and D-stage hazard control for the RISC-V pipeline.
// Tracks one non-pipelined long-latency unit (mul/div) with a register scoreboard.
module forward_hazard_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int LOP_LAT = 4,
    parameter int CNT_W   = 16,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*5-1:0]     d_rs_index,
    input  logic [NUM_SRC-1:0]       d_rs_used,
    input  logic [4:0]               d_rd_index,
    input  logic                     d_wb_en,
    input  logic                     d_is_lop,
    input  logic [NUM_SRC*5-1:0]     e_rs_index,
    input  logic [NUM_SRC-1:0]       e_rs_used,
    input  logic [4:0]               e_rd_index,
    input  logic                     e_wb_en,
    input  logic                     e_is_load,
    input  logic                     e_is_lop,
    input  logic [NUM_FWD*5-1:0]     fwd_rd_index,
    input  logic [NUM_FWD-1:0]       fwd_wb_en,
    output logic [NUM_SRC*SEL_W-1:0] rs_sel,
    output logic                     stall_d,
    output logic                     lop_wb,
    output logic [4:0]               lop_wb_rd,
    output logic                     lop_busy,
    output logic [CNT_W-1:0]         stall_count
);

    localparam int LW = $clog2(LOP_LAT + 1);

    logic [31:0]   busy;
    logic [31:0]   busy_nxt;
    logic [LW-1:0] cnt;
    logic [4:0]    lop_rd_q;
    logic          load_use_hz;
    logic          raw_hz;
    logic          waw_hz;
    logic          struct_hz;

    // Iterating oldest-to-youngest lets the youngest matching stage win.
    always_comb begin
        rs_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (e_rs_used[i] && e_rs_index[5*i +: 5] != 5'd0) begin
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (fwd_wb_en[k] && fwd_rd_index[5*k +: 5] == e_rs_index[5*i +: 5])
                        rs_sel[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
                end
            end
        end
    end

    always_comb begin
        load_use_hz = 1'b0;
        raw_hz      = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (d_rs_used[i] && d_rs_index[5*i +: 5] != 5'd0) begin
                if (e_is_load && e_wb_en && e_rd_index == d_rs_index[5*i +: 5])
                    load_use_hz = 1'b1;
                if (busy[d_rs_index[5*i +: 5]] ||
                    (e_is_lop && e_wb_en && e_rd_index == d_rs_index[5*i +: 5]))
                    raw_hz = 1'b1;
            end
        end
    end

    assign waw_hz    = d_wb_en && d_rd_index != 5'd0 &&
                       (busy[d_rd_index] || (e_is_lop && e_rd_index == d_rd_index));
    assign struct_hz = d_is_lop && (cnt > LW'(1) || e_is_lop);
    assign stall_d   = load_use_hz | raw_hz | waw_hz | struct_hz;

    assign lop_wb    = (cnt == LW'(1));
    assign lop_wb_rd = lop_rd_q;
    assign lop_busy  = (cnt != '0);

    // Clear is applied before set so a back-to-back op to the same rd keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (lop_wb)
            busy_nxt[lop_rd_q] = 1'b0;
        if (e_is_lop && e_wb_en && e_rd_index != 5'd0)
            busy_nxt[e_rd_index] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            cnt         <= '0;
            lop_rd_q    <= '0;
            stall_count <= '0;
        end else begin
            busy <= busy_nxt;
            if (e_is_lop) begin
                cnt      <= LW'(LOP_LAT);
                lop_rd_q <= e_rd_index;
            end else if (cnt != '0) begin
                cnt <= cnt - LW'(1);
            end
            if (stall_d && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Directed bench for forward_hazard_ctrl: expectations are queued when a step is
// driven and popped against the DUT outputs on the following falling edge.
module tb_forward_hazard_ctrl;

    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int LOP_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int SEL_W   = 2;

    localparam int F_SEL0  = 0;
    localparam int F_SEL1  = 1;
    localparam int F_STALL = 2;
    localparam int F_WB    = 3;
    localparam int F_WBRD  = 4;
    localparam int F_BUSY  = 5;
    localparam int F_CNT   = 6;

    logic                     clk;
    logic                     rst;
    logic [NUM_SRC*5-1:0]     d_rs_index;
    logic [NUM_SRC-1:0]       d_rs_used;
    logic [4:0]               d_rd_index;
    logic                     d_wb_en;
    logic                     d_is_lop;
    logic [NUM_SRC*5-1:0]     e_rs_index;
    logic [NUM_SRC-1:0]       e_rs_used;
    logic [4:0]               e_rd_index;
    logic                     e_wb_en;
    logic                     e_is_load;
    logic                     e_is_lop;
    logic [NUM_FWD*5-1:0]     fwd_rd_index;
    logic [NUM_FWD-1:0]       fwd_wb_en;
    logic [NUM_SRC*SEL_W-1:0] rs_sel;
    logic                     stall_d;
    logic                     lop_wb;
    logic [4:0]               lop_wb_rd;
    logic                     lop_busy;
    logic [CNT_W-1:0]         stall_count;

    logic [15:0]      exp_q[$];
    int               fld_q[$];
    string            tag_q[$];
    int               checks;
    int               errors;
    logic [CNT_W-1:0] exp_sc;

    forward_hazard_ctrl #(
        .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .LOP_LAT(LOP_LAT),
        .CNT_W(CNT_W), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .d_rs_index(d_rs_index), .d_rs_used(d_rs_used), .d_rd_index(d_rd_index),
        .d_wb_en(d_wb_en), .d_is_lop(d_is_lop),
        .e_rs_index(e_rs_index), .e_rs_used(e_rs_used), .e_rd_index(e_rd_index),
        .e_wb_en(e_wb_en), .e_is_load(e_is_load), .e_is_lop(e_is_lop),
        .fwd_rd_index(fwd_rd_index), .fwd_wb_en(fwd_wb_en),
        .rs_sel(rs_sel), .stall_d(stall_d), .lop_wb(lop_wb), .lop_wb_rd(lop_wb_rd),
        .lop_busy(lop_busy), .stall_count(stall_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A long op may only issue when the unit is idle or in its writeback cycle.
    always @(negedge clk) begin
        if (!rst && e_is_lop) begin
            checks++;
            assert (!(lop_busy && !lop_wb)) else begin
                errors++;
                $error("FAIL lop_issue_while_busy: observed busy=%0b wb=%0b expected idle or wb", lop_busy, lop_wb);
            end
        end
    end

    function automatic logic [15:0] observe(input int f);
        case (f)
            F_SEL0:  return 16'(rs_sel[1:0]);
            F_SEL1:  return 16'(rs_sel[3:2]);
            F_STALL: return 16'(stall_d);
            F_WB:    return 16'(lop_wb);
            F_WBRD:  return 16'(lop_wb_rd);
            F_BUSY:  return 16'(lop_busy);
            default: return 16'(stall_count);
        endcase
    endfunction

    // Driver tasks
    task automatic clear_inputs();
        d_rs_index = '0; d_rs_used = '0; d_rd_index = '0; d_wb_en = 1'b0; d_is_lop = 1'b0;
        e_rs_index = '0; e_rs_used = '0; e_rd_index = '0; e_wb_en = 1'b0;
        e_is_load = 1'b0; e_is_lop = 1'b0; fwd_rd_index = '0; fwd_wb_en = '0;
    endtask

    task automatic d_read0(input logic [4:0] idx);
        d_rs_index[4:0] = idx;
        d_rs_used       = 2'b01;
    endtask

    task automatic issue_lop(input logic [4:0] rd);
        e_is_lop   = 1'b1;
        e_wb_en    = 1'b1;
        e_rd_index = rd;
    endtask

    // Scoreboard
    task automatic push(input string tag, input int f, input logic [15:0] v);
        tag_q.push_back(tag);
        fld_q.push_back(f);
        exp_q.push_back(v);
    endtask

    task automatic expect_cycle(input string tag, input logic stall, input logic wb,
                                input logic [4:0] wbrd, input logic busy);
        push({tag, ".stall_d"}, F_STALL, 16'(stall));
        push({tag, ".lop_wb"}, F_WB, 16'(wb));
        if (wb)
            push({tag, ".lop_wb_rd"}, F_WBRD, 16'(wbrd));
        push({tag, ".lop_busy"}, F_BUSY, 16'(busy));
        push({tag, ".stall_count"}, F_CNT, 16'(exp_sc));
        if (stall && exp_sc != {CNT_W{1'b1}})
            exp_sc = exp_sc + 1'b1;
    endtask

    task automatic drain();
        logic [15:0] e;
        logic [15:0] o;
        int          f;
        string       t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            f = fld_q.pop_front();
            t = tag_q.pop_front();
            o = observe(f);
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", t, o, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_sc = '0;
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        push("reset.sel0", F_SEL0, 16'd0);
        push("reset.sel1", F_SEL1, 16'd0);
        expect_cycle("reset", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;

        // Forward priority
        clear_inputs();
        e_rs_index[4:0] = 5'd5; e_rs_used = 2'b01;
        fwd_rd_index = {5'd5, 5'd5}; fwd_wb_en = 2'b11;
        push("fwd_both.sel0", F_SEL0, 16'd1);
        push("fwd_both.sel1", F_SEL1, 16'd0);
        expect_cycle("fwd_both", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        fwd_wb_en = 2'b10; e_rs_index[9:5] = 5'd5; e_rs_used = 2'b11;
        push("fwd_old.sel0", F_SEL0, 16'd2);
        push("fwd_old.sel1", F_SEL1, 16'd2);
        tick();
        e_rs_index = '0; fwd_rd_index = '0; fwd_wb_en = 2'b11;
        push("fwd_x0.sel0", F_SEL0, 16'd0);
        push("fwd_x0.sel1", F_SEL1, 16'd0);
        tick();
        e_rs_index = {5'd6, 5'd6}; fwd_rd_index = {5'd9, 5'd6}; e_rs_used = 2'b10;
        push("fwd_unused.sel0", F_SEL0, 16'd0);
        push("fwd_unused.sel1", F_SEL1, 16'd1);
        tick();

        // Load-use: one stall, then the E bubble releases D
        clear_inputs();
        e_is_load = 1'b1; e_wb_en = 1'b1; e_rd_index = 5'd7;
        d_rs_index[9:5] = 5'd7; d_rs_used = 2'b10;
        expect_cycle("load_use", 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        clear_inputs();
        d_rs_index[9:5] = 5'd7; d_rs_used = 2'b10;
        expect_cycle("load_use.bubble", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        e_is_load = 1'b1; e_wb_en = 1'b1; e_rd_index = 5'd7; d_rs_used = 2'b01;
        expect_cycle("load_use.unused", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();

        // Long op to x9 with a dependent reader
        clear_inputs();
        issue_lop(5'd9);
        expect_cycle("lop9.T", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            clear_inputs();
            d_read0(5'd9);
            expect_cycle($sformatf("lop9.T+%0d", c), 1'b1, c == 4, 5'd9, 1'b1);
            tick();
        end
        expect_cycle("lop9.T+5", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();

        // Back-to-back long ops to x3, structural stalls, second issue in wb cycle
        clear_inputs();
        issue_lop(5'd3);
        expect_cycle("b2b.T", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            clear_inputs();
            d_is_lop = 1'b1;
            expect_cycle($sformatf("b2b.T+%0d", c), 1'b1, 1'b0, 5'd0, 1'b1);
            tick();
        end
        clear_inputs();
        issue_lop(5'd3);
        d_read0(5'd3);
        expect_cycle("b2b.T+4", 1'b1, 1'b1, 5'd3, 1'b1);
        tick();
        for (int c = 5; c <= 8; c++) begin
            clear_inputs();
            d_read0(5'd3);
            expect_cycle($sformatf("b2b.T+%0d", c), 1'b1, c == 8, 5'd3, 1'b1);
            tick();
        end
        expect_cycle("b2b.T+9", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();

        // WAW on x12; the stall counter saturates here
        clear_inputs();
        issue_lop(5'd12);
        d_wb_en = 1'b1; d_rd_index = 5'd12;
        expect_cycle("waw.T", 1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            clear_inputs();
            d_wb_en = 1'b1; d_rd_index = 5'd12;
            expect_cycle($sformatf("waw.T+%0d", c), 1'b1, c == 4, 5'd12, 1'b1);
            tick();
        end
        expect_cycle("waw.T+5", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();

        // Long op to x0 never blocks x0 readers or writers
        clear_inputs();
        issue_lop(5'd0);
        d_read0(5'd0); d_wb_en = 1'b1;
        expect_cycle("x0.T", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            clear_inputs();
            d_read0(5'd0); d_wb_en = 1'b1;
            expect_cycle($sformatf("x0.T+%0d", c), 1'b0, c == 4, 5'd0, 1'b1);
            tick();
        end
        expect_cycle("x0.T+5", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();

        // Asynchronous reset aborts an in-flight long op
        clear_inputs();
        issue_lop(5'd9);
        expect_cycle("rst_mid.T", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        clear_inputs();
        d_read0(5'd9);
        expect_cycle("rst_mid.T+1", 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        rst = 1'b1;
        exp_sc = '0;
        expect_cycle("rst_mid.T+2", 1'b0, 1'b0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            expect_cycle($sformatf("rst_mid.T+%0d", c), 1'b0, 1'b0, 5'd0, 1'b0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
